bus_master_if: RTL and testbench
================================

// Module: bus_master_if
// PURPOSE
//  Master-side bus interface: one per bus master (m0..m3) in front of the round-robin arbiter.
//  Turns a local strobe into a request/grant handshake with the arbiter (active-low req_/grnt_).
//  Once granted, it runs one address-strobe access on the shared bus, waits for slave rdy_,
//  returns read data to the local side and releases the bus.
// PARAMETERS
//  ADDR_W       30   shared-bus word address width
//  DATA_W       32   shared-bus data width
//  TIMEOUT_CYC  255  watchdog limit in cycles; used only with BUS_MASTER_TIMEOUT_EN
// PORTS
//  clk          in   1       single clock; all state on posedge clk
//  reset        in   1       asynchronous, active-low reset
//  cpu_as_      in   1       local access strobe, active-low; sampled only in IDLE
//  cpu_rw       in   1       1=READ, 0=WRITE
//  cpu_addr     in   ADDR_W  local address
//  cpu_wr_data  in   DATA_W  local write data
//  cpu_rd_data  out  DATA_W  read data; updated only on read completion
//  cpu_busy     out  1       high from the acceptance edge until the completion edge
//  cpu_done     out  1       one-cycle completion pulse
//  cpu_err      out  1       one-cycle error pulse with cpu_done (tied 0 without macro)
//  bus_req_     out  1       to arbiter, active-low
//  bus_grnt_    in   1       from arbiter, active-low
//  bus_as_      out  1       shared-bus address strobe, active-low
//  bus_rw       out  1       shared-bus direction
//  bus_addr     out  ADDR_W  shared-bus address
//  bus_wr_data  out  DATA_W  shared-bus write data
//  bus_rd_data  in   DATA_W  shared-bus read data
//  bus_rdy_     in   1       slave ready, active-low
// BEHAVIOUR
//  - Reset (async, reset==0): state=IDLE; bus_req_=1, bus_as_=1, bus_rw=READ, bus_addr=0,
//    bus_wr_data=0, cpu_rd_data=0, cpu_busy=0, cpu_done=0, cpu_err=0; watchdog cleared.
//  - All outputs are registered. Reset mid-transaction aborts silently: no done pulse; bus released.
//  - FSM IDLE->REQ->ACCESS->(WAIT)->IDLE:
//    IDLE:   cpu_as_==0 -> latch rw/addr/wr_data; bus_req_<=0; cpu_busy<=1; go REQ.
//            bus_grnt_ is ignored in IDLE (arbiter parks on a master).
//    REQ:    hold bus_req_=0; bus_grnt_==0 -> drive latched addr/rw/wr_data; bus_as_<=0; go ACCESS.
//    ACCESS: bus_as_<=1 (strobe is exactly 1 cycle); bus_rdy_==0 -> complete; else go WAIT.
//    WAIT:   hold bus_req_ and addr/rw/data; bus_rdy_==0 -> complete.
//    complete: if read, cpu_rd_data<=bus_rd_data; cpu_done<=1; cpu_busy<=0; bus_req_<=1;
//            bus_addr/bus_wr_data<=0; bus_rw<=READ; go IDLE.
//  - bus_req_ stays high for >=1 cycle after every completion, so the arbiter can rotate.
//    A back-to-back cpu_as_ is accepted in the IDLE cycle that follows completion.
//  - Non-owner drive: bus_as_=1, addr/data/rw at 0/READ, so the bus can be OR-muxed.
//  - cpu_as_/cpu fields changing after acceptance have no effect (request is latched).
//  - Grant deasserting while req_ is held is a protocol violation: it is ignored and the
//    transaction completes.
//  - Minimum latency: cpu_as_ sampled at edge N -> cpu_done high after edge N+2
//    (grant present at N+1, rdy_ low at N+2).
// CONFIGURATION
//  BUS_MASTER_TIMEOUT_EN defined:
//    - 8-bit watchdog counts cycles in ACCESS/WAIT and clears on every completion.
//    - Count reaching TIMEOUT_CYC with bus_rdy_ still high aborts the access:
//      bus_as_=1, bus_req_<=1, cpu_done=1 and cpu_err=1 for one cycle, cpu_rd_data unchanged, go IDLE.
//    - REQ is not timed.
//  BUS_MASTER_TIMEOUT_EN undefined: waits for rdy_ indefinitely; cpu_err is constant 0; no counter.
// STRUCTURE
//  - Shared bus defines header: ENABLE_=1'b0 / DISABLE_=1'b1, READ/WRITE, ADDR_W/DATA_W
//    defaults, RESET_ENABLE=1'b0.
//  - FSM state encoding is local to this module.
//  - One sub-module, bus_master_watchdog (counter + compare), instantiated only under the macro.
// TESTING
//  1. Read, grant immediate, rdy_ low in ACCESS: cpu_as_ at edge 0, addr=0x100, rd_data=0xDEADBEEF
//     -> bus_as_ low exactly 1 cycle; cpu_done after edge 2; cpu_rd_data=0xDEADBEEF.
//  2. Write with grant delayed 3 cycles, 2 rdy_ wait states -> bus_req_ low throughout;
//     addr/wr_data=0x5A5A5A5A stable until rdy_; cpu_rd_data unchanged.
//  3. Back-to-back requests -> bus_req_ high exactly 1 cycle between accesses;
//     4 instances + arbiter show grants rotating m0->m1->m2->m3.
//  4. Async reset asserted in WAIT -> all outputs at reset values immediately; no cpu_done.
//  5. cpu_as_ released and addr changed during REQ -> original latched addr/rw used; single done pulse.
//  6. Macro on, TIMEOUT_CYC=8, rdy_ never asserted -> cpu_done & cpu_err pulse at cycle 8 of ACCESS/WAIT;
//     bus_req_ released. Macro off, same stimulus -> busy held, no done.

Source files
------------

// File: rtl/bus_master_if_pkg.sv
// rtl/bus_master_if_pkg.sv - shared bus definitions for the bus master interface
//
// Purpose : active-low strobe levels, bus direction codes, default bus widths
//           and the reset assertion level shared by every bus master instance.
// Ports   : none (package).
package bus_master_if_pkg;

  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic READ         = 1'b1;
  localparam logic WRITE        = 1'b0;
  localparam int   ADDR_W_DEF   = 30;
  localparam int   DATA_W_DEF   = 32;
  localparam logic RESET_ENABLE = 1'b0;

endpackage

// File: rtl/bus_master_watchdog.sv
// rtl/bus_master_watchdog.sv - access watchdog counter for the bus master interface
//
// Purpose : counts cycles while an access is outstanding on the shared bus and
//           flags the cycle in which the configured limit is reached.
// Ports   : clk     - clock
//           reset   - asynchronous active-low reset
//           active  - master is in ACCESS or WAIT
//           clear   - access completing this cycle (slave ready)
//           expired - this is the TIMEOUT_CYC-th active cycle
module bus_master_watchdog
  import bus_master_if_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  input  logic clear,
  output logic expired
);

  // The counter holds the number of active cycles already elapsed, so the
  // limit is hit while it reads TIMEOUT_CYC-1.
  localparam logic [7:0] LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      cnt <= '0;
    end else if (!active || clear) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign expired = active && (cnt == LAST);

endmodule

// File: rtl/bus_master_if.sv
// rtl/bus_master_if.sv - master-side request/grant and address-strobe bus interface
//
// Purpose : latches a local access, requests the shared bus from the arbiter,
//           runs one single-cycle address-strobe access once granted, waits for
//           slave ready, returns read data and releases the bus.
//           Optional watchdog abort: define BUS_MASTER_TIMEOUT_EN.
// Ports   : clk, reset (async active-low)
//           cpu_as_, cpu_rw, cpu_addr, cpu_wr_data  - local request (strobe active-low)
//           cpu_rd_data, cpu_busy, cpu_done, cpu_err - local response
//           bus_req_ (out), bus_grnt_ (in)          - arbiter handshake, active-low
//           bus_as_, bus_rw, bus_addr, bus_wr_data   - shared-bus drive
//           bus_rd_data, bus_rdy_                    - shared-bus return, rdy_ active-low
module bus_master_if
  import bus_master_if_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_as_,
  input  logic              cpu_rw,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              bus_req_,
  input  logic              bus_grnt_,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACCESS,
    WAIT
  } state_t;

  state_t            state, state_next;
  logic              lat_rw, lat_rw_next;
  logic [ADDR_W-1:0] lat_addr, lat_addr_next;
  logic [DATA_W-1:0] lat_wd, lat_wd_next;
  logic              req_next, as_next, rw_next, busy_next, done_next;
  logic [ADDR_W-1:0] addr_next;
  logic [DATA_W-1:0] wd_next, rd_next;
  logic              finish;
  logic              timeout;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state       <= IDLE;
      lat_rw      <= READ;
      lat_addr    <= '0;
      lat_wd      <= '0;
      bus_req_    <= DISABLE_;
      bus_as_     <= DISABLE_;
      bus_rw      <= READ;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      cpu_rd_data <= '0;
      cpu_busy    <= 1'b0;
      cpu_done    <= 1'b0;
    end else begin
      state       <= state_next;
      lat_rw      <= lat_rw_next;
      lat_addr    <= lat_addr_next;
      lat_wd      <= lat_wd_next;
      bus_req_    <= req_next;
      bus_as_     <= as_next;
      bus_rw      <= rw_next;
      bus_addr    <= addr_next;
      bus_wr_data <= wd_next;
      cpu_rd_data <= rd_next;
      cpu_busy    <= busy_next;
      cpu_done    <= done_next;
    end
  end

  always_comb begin
    state_next    = state;
    lat_rw_next   = lat_rw;
    lat_addr_next = lat_addr;
    lat_wd_next   = lat_wd;
    req_next      = bus_req_;
    as_next       = bus_as_;
    rw_next       = bus_rw;
    addr_next     = bus_addr;
    wd_next       = bus_wr_data;
    rd_next       = cpu_rd_data;
    busy_next     = cpu_busy;
    done_next     = 1'b0;
    finish        = 1'b0;

    case (state)
      // Grant is ignored here: the arbiter may park its grant on this master.
      IDLE: begin
        if (cpu_as_ == ENABLE_) begin
          lat_rw_next   = cpu_rw;
          lat_addr_next = cpu_addr;
          lat_wd_next   = cpu_wr_data;
          req_next      = ENABLE_;
          busy_next     = 1'b1;
          state_next    = REQ;
        end
      end
      // Bus fields stay at 0/READ until ownership so the shared bus can be OR-muxed.
      REQ: begin
        if (bus_grnt_ == ENABLE_) begin
          rw_next    = lat_rw;
          addr_next  = lat_addr;
          wd_next    = lat_wd;
          as_next    = ENABLE_;
          state_next = ACCESS;
        end
      end
      // Grant is no longer looked at: a grant that drops mid-access is ignored.
      ACCESS, WAIT: begin
        as_next = DISABLE_;
        if (bus_rdy_ == ENABLE_) begin
          finish = 1'b1;
          if (lat_rw != WRITE) begin
            rd_next = bus_rd_data;
          end
        end else if (timeout) begin
          finish = 1'b1;
        end else begin
          state_next = WAIT;
        end
      end
      default: state_next = IDLE;
    endcase

    // Completion and watchdog abort share the release path; returning to IDLE
    // guarantees req_ is high for at least one cycle before the next request.
    if (finish) begin
      done_next  = 1'b1;
      busy_next  = 1'b0;
      req_next   = DISABLE_;
      addr_next  = '0;
      wd_next    = '0;
      rw_next    = READ;
      state_next = IDLE;
    end
  end

`ifdef BUS_MASTER_TIMEOUT_EN
  logic wd_expired;

  bus_master_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .active ((state == ACCESS) || (state == WAIT)),
    .clear  (bus_rdy_ == ENABLE_),
    .expired(wd_expired)
  );

  assign timeout = wd_expired;

  // Ready in the expiring cycle wins, so the error only accompanies a real abort.
  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      cpu_err <= 1'b0;
    end else begin
      cpu_err <= timeout && (bus_rdy_ == DISABLE_);
    end
  end
`else
  assign timeout = 1'b0;
  assign cpu_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_if.sv
// tb/tb_bus_master_if.sv - scoreboard testbench for bus_master_if
module tb_bus_master_if;
  import bus_master_if_pkg::*;

  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cpu_as_ = 1'b1;
  logic          cpu_rw = READ;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wr_data = '0;
  logic [DW-1:0] cpu_rd_data;
  logic          cpu_busy, cpu_done, cpu_err;
  logic          bus_req_;
  logic          bus_grnt_ = 1'b1;
  logic          bus_as_, bus_rw;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wr_data;
  logic [DW-1:0] bus_rd_data = '0;
  logic          bus_rdy_ = 1'b1;

  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_as_(cpu_as_), .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_rd_data(cpu_rd_data), .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_err(cpu_err),
    .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
    .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
    .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_)
  );

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] rd;
    logic          err;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] last_rd = '0;
  int            n_cmp = 0;
  int            n_err = 0;
  int            as_len = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: strobe width, bus fields during the strobe, and completions
  always @(negedge clk) begin
    if (reset == 1'b1) begin
      if (bus_as_ == ENABLE_) begin
        as_len++;
        if (exp_q.size() == 0) begin
          check("as_unexpected", 1, 0);
        end else begin
          check("bus_addr", bus_addr, exp_q[0].addr);
          check("bus_rw", bus_rw, exp_q[0].rw);
          check("bus_wr_data", bus_wr_data, exp_q[0].wd);
        end
      end else if (as_len != 0) begin
        check("as_len", as_len, 1);
        as_len = 0;
      end
      if (cpu_done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("cpu_rd_data", cpu_rd_data, e.rd);
          check("cpu_err", cpu_err, e.err);
        end
      end
    end else begin
      as_len = 0;
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_req"}, bus_req_, 1);
    check({tag, "_as"}, bus_as_, 1);
    check({tag, "_rw"}, bus_rw, READ);
    check({tag, "_addr"}, bus_addr, 0);
    check({tag, "_wd"}, bus_wr_data, 0);
    check({tag, "_rd"}, cpu_rd_data, 0);
    check({tag, "_busy"}, cpu_busy, 0);
    check({tag, "_done"}, cpu_done, 0);
    check({tag, "_err"}, cpu_err, 0);
  endtask

  // Called at a negedge; returns at the negedge inside the ACCESS cycle.
  task automatic start_access(input logic rw, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                              input int gdly, input bit chg, input logic exp_err);
    exp_t e;
    e.rw = rw; e.addr = addr; e.wd = wd; e.err = exp_err;
    e.rd = (rw == READ && !exp_err) ? rd : last_rd;
    last_rd = e.rd;
    exp_q.push_back(e);
    cpu_as_ = 1'b0; cpu_rw = rw; cpu_addr = addr; cpu_wr_data = wd;
    bus_rd_data = rd; bus_grnt_ = 1'b1; bus_rdy_ = 1'b1;
    @(negedge clk);
    check("acc_busy", cpu_busy, 1);
    check("acc_req", bus_req_, 0);
    check("acc_as", bus_as_, 1);
    cpu_as_ = 1'b1;
    if (chg) begin
      cpu_addr = ~addr; cpu_rw = ~rw; cpu_wr_data = ~wd;
    end
    for (int i = 0; i < gdly; i++) begin
      @(negedge clk);
      check("req_hold", bus_req_, 0);
      check("req_as", bus_as_, 1);
      check("req_addr_idle", bus_addr, 0);
      check("req_done", cpu_done, 0);
    end
    bus_grnt_ = 1'b0;
    @(negedge clk);
    check("access_as", bus_as_, 0);
    check("access_done", cpu_done, 0);
  endtask

  task automatic finish_access(input logic [AW-1:0] addr, input logic [DW-1:0] wd, input int wst);
    for (int i = 0; i < wst; i++) begin
      @(negedge clk);
      check("wait_as", bus_as_, 1);
      check("wait_req", bus_req_, 0);
      check("wait_addr", bus_addr, addr);
      check("wait_wd", bus_wr_data, wd);
      check("wait_done", cpu_done, 0);
    end
    bus_rdy_ = 1'b0;
    @(negedge clk);
    check("cmp_done", cpu_done, 1);
    check("cmp_busy", cpu_busy, 0);
    check("cmp_req", bus_req_, 1);
    check("cmp_addr", bus_addr, 0);
    check("cmp_wd", bus_wr_data, 0);
    check("cmp_rw", bus_rw, READ);
    bus_rdy_ = 1'b1;
    bus_grnt_ = 1'b1;
  endtask

  task automatic txn(input logic rw, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                     input logic [DW-1:0] rd, input int gdly, input int wst, input bit chg);
    start_access(rw, addr, wd, rd, gdly, chg, 1'b0);
    finish_access(addr, wd, wst);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    check("idle_done", cpu_done, 0);
    check("idle_req", bus_req_, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_reset_vals("rst_async");
    exp_q.delete();
    last_rd = '0;
    bus_grnt_ = 1'b1;
    bus_rdy_ = 1'b1;
    @(negedge clk);
    check("rst_done", cpu_done, 0);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // minimum latency read, immediate grant, ready in ACCESS
    txn(READ, 30'h100, 32'h0, 32'hDEADBEEF, 0, 0, 1'b0);
    idle_cycle();
    check("rd_after_read", cpu_rd_data, 32'hDEADBEEF);

    // write with late grant and two wait states; read data must not move
    txn(WRITE, 30'h2AA, 32'h5A5A5A5A, 32'h11111111, 3, 2, 1'b0);
    idle_cycle();
    check("rd_after_write", cpu_rd_data, 32'hDEADBEEF);

    // back-to-back: next strobe lands in the IDLE cycle after completion
    txn(READ, 30'h3FFF_FFFF, 32'hA5A5A5A5, 32'h12345678, 0, 0, 1'b0);
    txn(WRITE, 30'h0, 32'hFFFFFFFF, 32'h0, 1, 1, 1'b0);
    txn(READ, 30'h1234, 32'h0, 32'hCAFEF00D, 2, 3, 1'b0);
    idle_cycle();

    // local fields change after acceptance: latched request is used
    txn(READ, 30'h0ABC, 32'h13579BDF, 32'h2468ACE0, 2, 1, 1'b1);
    idle_cycle();
    check("rd_after_chg", cpu_rd_data, 32'h2468ACE0);

    // async reset in WAIT: immediate reset values, no completion
    start_access(READ, 30'h55, 32'h0, 32'h77777777, 0, 1'b0, 1'b0);
    @(negedge clk);
    check("wait_state_req", bus_req_, 0);
    do_reset();
    idle_cycle();
    check_reset_vals("post_rst");

    // slave never ready
`ifdef BUS_MASTER_TIMEOUT_EN
    start_access(READ, 30'h99, 32'h0, 32'h88888888, 0, 1'b0, 1'b1);
    for (int i = 0; i < TO - 1; i++) begin
      @(negedge clk);
      check("to_wait_done", cpu_done, 0);
      check("to_wait_busy", cpu_busy, 1);
    end
    @(negedge clk);
    check("to_done", cpu_done, 1);
    check("to_err", cpu_err, 1);
    check("to_req", bus_req_, 1);
    check("to_as", bus_as_, 1);
    check("to_rd", cpu_rd_data, 0);
    bus_grnt_ = 1'b1;
    idle_cycle();
    check("to_err_pulse", cpu_err, 0);
    txn(READ, 30'h9A, 32'h0, 32'h0BADF00D, 0, 0, 1'b0);
    idle_cycle();
`else
    start_access(READ, 30'h99, 32'h0, 32'h88888888, 0, 1'b0, 1'b0);
    for (int i = 0; i < 3 * TO; i++) begin
      @(negedge clk);
      check("noto_done", cpu_done, 0);
      check("noto_busy", cpu_busy, 1);
      check("noto_req", bus_req_, 0);
    end
    check("noto_err", cpu_err, 0);
    do_reset();
    idle_cycle();
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
